// File: rtl/spi_word_rx.sv
// SPI mode-0 slave receiver oversampled by clk: assembles MSB-first frames of
// exactly WIDTH bits into spi_data and shifts the held word back out on spi_miso.
//
// Handshake: data_valid and frame_err are single-cycle strobes with no ready.
// data_valid is high in the same cycle as the newly committed spi_data.
// frame_err marks a rejected frame, and spi_data is left untouched.
module spi_word_rx #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_cs,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [WIDTH-1:0] spi_data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cs_sync_q, cs_sync_d;
    logic [2:0]       sck_sync_q, sck_sync_d;
    logic [2:0]       mosi_sync_q, mosi_sync_d;
    logic [1:0]       flush_q, flush_d;
    logic             armed_q, armed_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

    logic cs_fall, cs_rise, sck_rise, sck_fall, mosi_s;

    assign cs_fall  =  cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise  = ~cs_sync_q[2] &  cs_sync_q[1];
    assign sck_rise = ~sck_sync_q[2] &  sck_sync_q[1];
    assign sck_fall =  sck_sync_q[2] & ~sck_sync_q[1];
    assign mosi_s   =  mosi_sync_q[1];

    always_comb begin
        state_d      = state_q;
        cs_sync_d    = {cs_sync_q[1:0], spi_cs};
        sck_sync_d   = {sck_sync_q[1:0], spi_clk};
        mosi_sync_d  = {mosi_sync_q[1:0], spi_mosi};
        flush_d      = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
        // A frame may only start once the synchronized CS has been seen high
        // after reset; a CS already low at reset release is not a frame start.
        armed_d      = armed_q | ((flush_q == 2'd2) & cs_sync_q[1]);
        bit_cnt_d    = bit_cnt_q;
        overrun_d    = overrun_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                    rx_sr_d   = '0;
                    tx_sr_d   = data_q;
                end
            end
            SHIFT: begin
                // CS rise wins over any SCK edge detected in the same cycle.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q == CW'(WIDTH) && !overrun_q) begin
                        data_d       = rx_sr_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
                    if (bit_cnt_q < CW'(WIDTH)) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cs_sync_q    <= 3'b111;
            sck_sync_q   <= 3'b000;
            mosi_sync_q  <= 3'b000;
            flush_q      <= 2'd0;
            armed_q      <= 1'b0;
            bit_cnt_q    <= '0;
            overrun_q    <= 1'b0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            data_q       <= RST_DATA;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_sync_q    <= cs_sync_d;
            sck_sync_q   <= sck_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            flush_q      <= flush_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            overrun_q    <= overrun_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign spi_miso   = (state_q == SHIFT) & tx_sr_q[WIDTH-1];
    assign spi_data   = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == SHIFT);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// Bench for spi_word_rx: host-side SPI driver, a frame-level model of which
// frames commit, and a per-cycle compare of pulses and the held word.
module tb_spi_word_rx;

    localparam int             W   = 16;
    localparam logic [W-1:0]   RST = 16'h0000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         spi_cs = 1'b1;
    logic         spi_clk = 1'b0;
    logic         spi_mosi = 1'b0;
    logic         spi_miso;
    logic [W-1:0] spi_data;
    logic         data_valid;
    logic         frame_err;
    logic         busy;
    logic         dbg_state;

    int checks = 0;
    int failures = 0;

    // Scoreboard entries: {1'b1, word} for a commit, {1'b0, 'x} for a rejection.
    logic [W:0]   exp_q[$];
    logic [W-1:0] mdl_word;
    logic [W-1:0] shown;
    logic [W-1:0] mw;

    spi_word_rx #(.WIDTH(W), .RST_DATA(RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_data   (spi_data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: 2 ns after each rising edge, outputs are settled.
    initial begin : compare
        logic [W:0] e;
        shown = RST;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) shown = RST;
            if (data_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[W]) begin
                        chk("dv_kind", {30'd0, data_valid, frame_err}, 32'd2);
                        shown = e[W-1:0];
                    end else begin
                        chk("fe_kind", {30'd0, data_valid, frame_err}, 32'd1);
                    end
                end
            end
            chk("held_word", {16'd0, spi_data}, {16'd0, shown});
            if (!busy) chk("miso_idle", {31'd0, spi_miso}, 32'd0);
        end
    end

    // One host frame of n bits (MSB of bits[n-1:0] first). merge_last raises CS
    // together with the last SCK rise; rst_after>0 pulses reset after that many bits.
    task automatic frame(input logic [31:0] bits, input int n, input bit merge_last,
                         input int rst_after, output logic [W-1:0] miso_word);
        int           h;
        int           lat;
        bit           expect_pulse;
        bit           commits;
        logic [W-1:0] start_word;
        expect_pulse = 1'b1;
        start_word   = mdl_word;
        miso_word    = '0;
        h            = $urandom_range(6, 4);
        commits      = (n == W) && !merge_last;
        if (commits) exp_q.push_back({1'b1, bits[W-1:0]});
        else         exp_q.push_back({1'b0, {W{1'b0}}});

        @(negedge clk);
        spi_mosi = (n > 0) ? bits[n-1] : 1'b0;
        spi_cs   = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_start", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);

        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            repeat (h) @(negedge clk);
            if (n - 1 - i < W) miso_word = {miso_word[W-2:0], spi_miso};
            spi_clk = 1'b1;
            if (merge_last && i == 0) begin
                spi_cs = 1'b1;
                break;
            end
            repeat (h) @(negedge clk);
            spi_clk = 1'b0;
            if (rst_after == n - i) begin
                @(negedge clk);
                reset = 1'b0;
                exp_q.delete();
                mdl_word     = RST;
                expect_pulse = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                chk("rst_data", {16'd0, spi_data}, {16'd0, RST});
                chk("rst_busy", {31'd0, busy}, 32'd0);
            end
        end
        if (!merge_last) begin
            repeat (h + 1) @(negedge clk);
            spi_cs = 1'b1;
        end

        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ((data_valid || frame_err) && lat == 0) lat = k;
        end
        if (expect_pulse) chk("pulse_lat", lat, 32'd3);
        else              chk("no_pulse", lat, 32'd0);
        spi_clk = 1'b0;
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("drain", exp_q.size(), 32'd0);
        if (expect_pulse && commits) mdl_word = bits[W-1:0];
        if (commits && rst_after <= 0) chk("miso_model", {16'd0, miso_word}, {16'd0, start_word});
        repeat ($urandom_range(8, 4)) @(negedge clk);
    endtask

    initial begin : main
        int n;
        logic [31:0] r;
        mdl_word = RST;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_spi_data", {16'd0, spi_data}, 32'h0000);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy0", {31'd0, busy}, 32'd0);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        repeat (10) @(negedge clk);

        frame(32'h1234, 16, 1'b0, -1, mw);
        chk("t1_data", {16'd0, spi_data}, 32'h1234);

        frame(32'hA5C3, 16, 1'b0, -1, mw);
        frame(32'h0000, 16, 1'b0, -1, mw);
        chk("readback", {16'd0, mw}, 32'hA5C3);
        chk("t2_data", {16'd0, spi_data}, 32'h0000);

        frame(32'hA5C3, 16, 1'b0, -1, mw);
        frame(32'h1234, 15, 1'b0, -1, mw);
        frame(32'h1ABCD, 17, 1'b0, -1, mw);
        chk("t3_retain", {16'd0, spi_data}, 32'hA5C3);

        frame(32'hFFFF, 16, 1'b0, 8, mw);
        chk("t4_after_rst", {16'd0, spi_data}, 32'h0000);
        frame(32'h0042, 16, 1'b0, -1, mw);
        chk("t4_commit", {16'd0, spi_data}, 32'h0042);

        frame(32'h0000, 0, 1'b0, -1, mw);
        chk("t5_zero_bit", {16'd0, spi_data}, 32'h0042);
        frame(32'hFFFF, 16, 1'b1, -1, mw);
        chk("t5_merge", {16'd0, spi_data}, 32'h0042);

        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(4, 0))
                0:       n = 15;
                1:       n = 17;
                default: n = 16;
            endcase
            r = $urandom;
            frame(r, n, 1'b0, -1, mw);
            chk("rand_data", {16'd0, spi_data}, {16'd0, mdl_word});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
